decoder_pulse_nto2n: RTL

Parametrised, registered N-to-2^N one-hot decoder with timed output strobes, the successor to the fixed 2-to-4 line decoder. It drives one-hot select/strobe lines (chip selects, interrupt acknowledges, register write enables) from a binary index. Each request produces either a held level or a strobe of programmable width, with a one-deep pending slot so back-to-back requests produce gapless strobes.

---
 rtl/decoder_pulse_nto2n_pkg.sv | 21 ++
 rtl/decoder_pulse_nto2n_pulse_counter.sv | 31 +++
 rtl/decoder_pulse_nto2n.sv | 118 +++++++++++
 3 files changed

// File: rtl/decoder_pulse_nto2n_pkg.sv
// Shared state encoding and one-hot helper for the pulse decoder.
// onehot() is sized for the widest supported index (8 bits, 256 outputs).
package decoder_pulse_nto2n_pkg;

  localparam int MAX_SEL = 8;
  localparam int MAX_OUT = 1 << MAX_SEL;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  function automatic logic [MAX_OUT-1:0] onehot(input logic [MAX_SEL-1:0] index,
                                                input int                 width);
    logic [MAX_OUT-1:0] v;
    v = '0;
    if (int'(index) < width) v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_pulse_nto2n_pulse_counter.sv
// Load/decrement strobe-length counter; tc flags the last cycle of a strobe.
// Decrement saturates at 1 so an active strobe never wraps.
module decoder_pulse_nto2n_pulse_counter #(
  parameter  int PULSE_CYCLES = 1,
  localparam int CW           = $clog2(PULSE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic load,
  input  logic dec,
  output logic tc
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(PULSE_CYCLES);
    end else if (dec && (cnt > CW'(1))) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == CW'(1));

endmodule

// File: rtl/decoder_pulse_nto2n.sv
// Registered N-to-2^N one-hot decoder with timed strobes (or held levels)
// and a one-deep pending slot so back-to-back requests give gapless strobes.
module decoder_pulse_nto2n
  import decoder_pulse_nto2n_pkg::*;
#(
  parameter  int SEL_WIDTH    = 2,
  parameter  int PULSE_CYCLES = 1,
  parameter  int PULSE_MODE   = 1,
  localparam int NOUT         = 1 << SEL_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Req,
  input  logic [SEL_WIDTH-1:0] A,
  input  logic                 Clear,
  output logic [NOUT-1:0]      B,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Overflow
);

  state_t               state;
  logic                 pend_vld;
  logic [SEL_WIDTH-1:0] pend_idx;
  logic [NOUT-1:0]      oh_a;
  logic [NOUT-1:0]      oh_p;
  logic                 acc;
  logic                 tc;
  logic                 ctr_clr;
  logic                 ctr_load;
  logic                 ctr_dec;

  assign oh_a  = NOUT'(onehot(MAX_SEL'(A), NOUT));
  assign oh_p  = NOUT'(onehot(MAX_SEL'(pend_idx), NOUT));
  assign acc   = Req && Ready && !Clear;
  assign Ready = !pend_vld;
  assign Busy  = (B != '0) || pend_vld;

  always_comb begin
    ctr_clr  = 1'b0;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;
    if (PULSE_MODE != 0) begin
      if (Clear) begin
        ctr_clr = 1'b1;
      end else if (state == IDLE) begin
        ctr_load = acc;
      end else if (tc) begin
        // Reload on handoff so the next strobe follows with no zero cycle.
        if (pend_vld || acc) ctr_load = 1'b1;
        else                 ctr_clr  = 1'b1;
      end else begin
        ctr_dec = 1'b1;
      end
    end
  end

  decoder_pulse_nto2n_pulse_counter #(
    .PULSE_CYCLES (PULSE_CYCLES)
  ) u_pulse_counter (
    .clock (clock),
    .reset (reset),
    .clr   (ctr_clr),
    .load  (ctr_load),
    .dec   (ctr_dec),
    .tc    (tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      B        <= '0;
      pend_vld <= 1'b0;
      pend_idx <= '0;
      Overflow <= 1'b0;
    end else begin
      // Clear drops a colliding request silently, so it never overflows.
      Overflow <= Req && !Ready && !Clear;
      if (Clear) begin
        state    <= IDLE;
        B        <= '0;
        pend_vld <= 1'b0;
      end else if (PULSE_MODE == 0) begin
        if (acc) B <= oh_a;
      end else begin
        case (state)
          IDLE: begin
            if (acc) begin
              state <= ACTIVE;
              B     <= oh_a;
            end
          end
          ACTIVE: begin
            if (tc) begin
              if (pend_vld) begin
                B        <= oh_p;
                pend_vld <= 1'b0;
              end else if (acc) begin
                B <= oh_a;
              end else begin
                state <= IDLE;
                B     <= '0;
              end
            end else if (acc) begin
              pend_vld <= 1'b1;
              pend_idx <= A;
            end
          end
          default: begin
            state <= IDLE;
            B     <= '0;
          end
        endcase
      end
    end
  end

endmodule
